// File: rtl/jtkunio_gfx_pkg.sv
// Shared constants for the graphics ROM arbiter: FSM state encoding and
// downstream region codes placed in the top bit of sdram_addr.
package jtkunio_gfx_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic SCR_RGN = 1'b0;
  localparam logic OBJ_RGN = 1'b1;

endpackage

// File: rtl/jtkunio_gfx_slot.sv
// One requester cache slot: last served tag/data plus a valid flag.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   cs, addr     live request from the layer fetcher
//   busy         downstream transfer currently belongs to this slot
//   fly_addr     address of the transfer in flight
//   wr, wdata    store fly_addr/wdata into the slot
//   data         registered cached word
//   hit_c        slot holds the word for addr
//   ok_c         hit qualified by cs
//   pending_c    slot needs a downstream fetch
module jtkunio_gfx_slot
  import jtkunio_gfx_pkg::*;
#(
  parameter int unsigned AW = 17,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          busy,
  input  logic [AW-1:0] fly_addr,
  input  logic          wr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] data,
  output logic          hit_c,
  output logic          ok_c,
  output logic          pending_c
);

  logic [AW-1:0] tag;
  logic          valid;

  // Data is stored under the in-flight tag, not the live address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag   <= '0;
      data  <= '0;
      valid <= 1'b0;
    end else if (wr) begin
      tag   <= fly_addr;
      data  <= wdata;
      valid <= 1'b1;
    end
  end

  // A miss already being fetched for the same address is not re-requested.
  always_comb begin
    hit_c     = valid && (tag == addr);
    ok_c      = cs && hit_c;
    pending_c = cs && !hit_c && !(busy && (fly_addr == addr));
  end

endmodule

// File: rtl/jtkunio_gfx_arb.sv
// Graphics ROM arbiter: shares one SDRAM read slot between the scroll and
// object fetchers, caching the last word per requester. Scroll has priority
// but objects are forced through after MAXWAIT consecutive scroll grants.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   scr_cs/addr, scr_data/ok        scroll requester
//   obj_cs/addr, obj_data/ok        object requester
//   sdram_cs/addr, sdram_data/ok    downstream read port, addr = {region, addr}
module jtkunio_gfx_arb
  import jtkunio_gfx_pkg::*;
#(
  parameter int unsigned AW      = 17,
  parameter int unsigned DW      = 32,
  parameter int unsigned MAXWAIT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          scr_cs,
  input  logic [AW-1:0] scr_addr,
  output logic [DW-1:0] scr_data,
  output logic          scr_ok,
  input  logic          obj_cs,
  input  logic [AW-1:0] obj_addr,
  output logic [DW-1:0] obj_data,
  output logic          obj_ok,
  output logic          sdram_cs,
  output logic [AW:0]   sdram_addr,
  input  logic [DW-1:0] sdram_data,
  input  logic          sdram_ok
);

  localparam int unsigned SW = (MAXWAIT < 4) ? 2 : $clog2(MAXWAIT + 1);

  logic [0:0]    state, state_nxt;
  logic          gnt, gnt_nxt;
  logic          sdram_cs_nxt;
  logic [AW:0]   sdram_addr_nxt;
  logic [SW-1:0] starve, starve_nxt;

  logic          scr_busy_c, obj_busy_c, scr_wr_c, obj_wr_c;
  logic          scr_pend_c, obj_pend_c, obj_win_c;
  logic          scr_hit_c, obj_hit_c;
  logic [AW-1:0] fly_addr_c;

  // Transfer ownership and write strobes for the two slots.
  always_comb begin
    fly_addr_c = sdram_addr[AW-1:0];
    scr_busy_c = (state == ST_WAIT) && (gnt == SCR_RGN);
    obj_busy_c = (state == ST_WAIT) && (gnt == OBJ_RGN);
    scr_wr_c   = scr_busy_c && sdram_ok;
    obj_wr_c   = obj_busy_c && sdram_ok;
    obj_win_c  = obj_pend_c && (!scr_pend_c || (starve == SW'(MAXWAIT)));
  end

  jtkunio_gfx_slot #(.AW(AW), .DW(DW)) u_scr (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs        (scr_cs),
    .addr      (scr_addr),
    .busy      (scr_busy_c),
    .fly_addr  (fly_addr_c),
    .wr        (scr_wr_c),
    .wdata     (sdram_data),
    .data      (scr_data),
    .hit_c     (scr_hit_c),
    .ok_c      (scr_ok),
    .pending_c (scr_pend_c)
  );

  jtkunio_gfx_slot #(.AW(AW), .DW(DW)) u_obj (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs        (obj_cs),
    .addr      (obj_addr),
    .busy      (obj_busy_c),
    .fly_addr  (fly_addr_c),
    .wr        (obj_wr_c),
    .wdata     (sdram_data),
    .data      (obj_data),
    .hit_c     (obj_hit_c),
    .ok_c      (obj_ok),
    .pending_c (obj_pend_c)
  );

  // FSM and downstream registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      gnt        <= SCR_RGN;
      sdram_cs   <= 1'b0;
      sdram_addr <= '0;
      starve     <= '0;
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      sdram_cs   <= sdram_cs_nxt;
      sdram_addr <= sdram_addr_nxt;
      starve     <= starve_nxt;
    end
  end

  // Next-state, grant and starvation accounting.
  always_comb begin
    state_nxt      = state;
    gnt_nxt        = gnt;
    sdram_cs_nxt   = sdram_cs;
    sdram_addr_nxt = sdram_addr;
    starve_nxt     = starve;
    if (!obj_pend_c) starve_nxt = '0;
    case (state)
      ST_IDLE: begin
        if (scr_pend_c || obj_pend_c) begin
          gnt_nxt        = obj_win_c;
          sdram_addr_nxt = obj_win_c ? {OBJ_RGN, obj_addr} : {SCR_RGN, scr_addr};
          sdram_cs_nxt   = 1'b1;
          state_nxt      = ST_WAIT;
          if (obj_win_c)
            starve_nxt = '0;
          else if (obj_pend_c && (starve != SW'(MAXWAIT)))
            starve_nxt = starve + SW'(1);
        end
      end
      ST_WAIT: begin
        if (sdram_ok) begin
          sdram_cs_nxt = 1'b0;
          state_nxt    = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_jtkunio_gfx_arb.sv
module tb_jtkunio_gfx_arb;

  localparam int unsigned AW = 17;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst_n;
  logic          scr_cs, obj_cs;
  logic [AW-1:0] scr_addr, obj_addr;
  logic [DW-1:0] scr_data, obj_data;
  logic          scr_ok, obj_ok;
  logic          sdram_cs;
  logic [AW:0]   sdram_addr;
  logic [DW-1:0] sdram_data;
  logic          sdram_ok;

  int tests = 0;
  int fails = 0;

  jtkunio_gfx_arb #(.AW(AW), .DW(DW), .MAXWAIT(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scr_cs     (scr_cs),
    .scr_addr   (scr_addr),
    .scr_data   (scr_data),
    .scr_ok     (scr_ok),
    .obj_cs     (obj_cs),
    .obj_addr   (obj_addr),
    .obj_data   (obj_data),
    .obj_ok     (obj_ok),
    .sdram_cs   (sdram_cs),
    .sdram_addr (sdram_addr),
    .sdram_data (sdram_data),
    .sdram_ok   (sdram_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a downstream request and check its address.
  task automatic wait_req(input string tag, input logic [AW:0] exp);
    int n = 0;
    while (!sdram_cs && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_cs"}, 64'(sdram_cs), 64'd1);
    check({tag, "_addr"}, 64'(sdram_addr), 64'(exp));
  endtask

  // Raise sdram_ok after 'delay' cycles; caller finishes with end_ok.
  task automatic give_ok(input logic [DW-1:0] d, input int delay);
    repeat (delay) tick();
    sdram_data = d;
    sdram_ok   = 1'b1;
  endtask

  task automatic end_ok();
    tick();
    sdram_ok = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] a;
    rst_n = 1'b0; scr_cs = 1'b0; obj_cs = 1'b0;
    scr_addr = '0; obj_addr = '0; sdram_data = '0; sdram_ok = 1'b0;
    tick(); tick();
    check("rst_sdram_cs", 64'(sdram_cs), 64'd0);
    check("rst_sdram_addr", 64'(sdram_addr), 64'd0);
    check("rst_scr_ok", 64'(scr_ok), 64'd0);
    check("rst_obj_ok", 64'(obj_ok), 64'd0);
    check("rst_scr_data", 64'(scr_data), 64'd0);
    check("rst_obj_data", 64'(obj_data), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single miss, then hits without new requests
    scr_cs = 1'b1; scr_addr = 17'h01230;
    #1;
    check("miss_ok_low", 64'(scr_ok), 64'd0);
    check("miss_cs_n", 64'(sdram_cs), 64'd0);
    tick();
    check("miss_cs_n1", 64'(sdram_cs), 64'd1);
    check("miss_addr", 64'(sdram_addr), 64'h01230);
    give_ok(32'hA5A5_0001, 4);
    check("miss_ok_cycle", 64'(scr_ok), 64'd0);
    end_ok();
    check("miss_scr_ok", 64'(scr_ok), 64'd1);
    check("miss_scr_data", 64'(scr_data), 64'hA5A5_0001);
    check("miss_cs_drop", 64'(sdram_cs), 64'd0);
    scr_cs = 1'b0;
    #1;
    check("cs_low_ok", 64'(scr_ok), 64'd0);
    tick();
    scr_cs = 1'b1;
    #1;
    check("rehit_ok", 64'(scr_ok), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rehit_no_cs", 64'(sdram_cs), 64'd0);
    end

    // Simultaneous requests: scroll first, object after the gap
    scr_addr = 17'h00010; obj_cs = 1'b1; obj_addr = 17'h00020;
    wait_req("sim_scr", {1'b0, 17'h00010});
    give_ok(32'h1111_0010, 2);
    end_ok();
    check("sim_gap", 64'(sdram_cs), 64'd0);
    check("sim_scr_ok", 64'(scr_ok), 64'd1);
    tick();
    check("sim_obj_cs", 64'(sdram_cs), 64'd1);
    check("sim_obj_addr", 64'(sdram_addr), 64'({1'b1, 17'h00020}));
    give_ok(32'h2222_0020, 1);
    end_ok();
    check("sim_obj_ok", 64'(obj_ok), 64'd1);
    check("sim_obj_data", 64'(obj_data), 64'h2222_0020);
    check("sim_scr_still", 64'(scr_data), 64'h1111_0010);

    // Starvation: three scroll grants, then the object is forced through
    obj_addr = 17'h00300; scr_addr = 17'h00400;
    a = 17'h00400;
    for (int i = 0; i < 3; i++) begin
      wait_req("starve_scr", {1'b0, a});
      give_ok(32'h3000_0000 + 32'(i), 1);
      a = a + 17'd2;
      scr_addr = a;
      end_ok();
    end
    wait_req("starve_obj", {1'b1, 17'h00300});
    give_ok(32'h4444_0300, 1);
    end_ok();
    check("starve_obj_ok", 64'(obj_ok), 64'd1);
    check("starve_obj_data", 64'(obj_data), 64'h4444_0300);
    wait_req("starve_next", {1'b0, 17'h00406});
    give_ok(32'h5555_0406, 1);
    end_ok();
    check("starve_scr_ok", 64'(scr_ok), 64'd1);
    obj_cs = 1'b0;

    // Address change during WAIT
    scr_addr = 17'h00040;
    wait_req("chg_first", {1'b0, 17'h00040});
    tick();
    scr_addr = 17'h00042;
    tick();
    check("chg_hold_addr", 64'(sdram_addr), 64'h00040);
    give_ok(32'hDEAD_0040, 1);
    end_ok();
    check("chg_ok_low", 64'(scr_ok), 64'd0);
    check("chg_gap", 64'(sdram_cs), 64'd0);
    scr_addr = 17'h00040;
    #1;
    check("chg_old_hit", 64'(scr_ok), 64'd1);
    check("chg_old_data", 64'(scr_data), 64'hDEAD_0040);
    scr_addr = 17'h00042;
    wait_req("chg_reissue", {1'b0, 17'h00042});
    give_ok(32'hBEEF_0042, 2);
    end_ok();
    check("chg_new_ok", 64'(scr_ok), 64'd1);
    check("chg_new_data", 64'(scr_data), 64'hBEEF_0042);

    // Address change on the ok cycle
    scr_addr = 17'h00050;
    wait_req("okchg_first", {1'b0, 17'h00050});
    give_ok(32'h0000_0050, 1);
    scr_addr = 17'h00052;
    end_ok();
    check("okchg_ok_low", 64'(scr_ok), 64'd0);
    check("okchg_gap", 64'(sdram_cs), 64'd0);
    tick();
    check("okchg_cs", 64'(sdram_cs), 64'd1);
    check("okchg_addr", 64'(sdram_addr), 64'h00052);
    give_ok(32'h0000_0052, 1);
    end_ok();
    check("okchg_done", 64'(scr_data), 64'h0000_0052);

    // Reset in the middle of a transfer
    obj_cs = 1'b1;
    #1;
    check("pre_rst_obj_ok", 64'(obj_ok), 64'd1);
    scr_addr = 17'h00060;
    wait_req("rst_wait", {1'b0, 17'h00060});
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_cs", 64'(sdram_cs), 64'd0);
    check("midrst_scr_ok", 64'(scr_ok), 64'd0);
    check("midrst_obj_ok", 64'(obj_ok), 64'd0);
    obj_cs = 1'b0;
    tick();
    rst_n = 1'b1;
    scr_addr = 17'h00100;
    #1;
    check("postrst_miss", 64'(scr_ok), 64'd0);
    wait_req("postrst_req", {1'b0, 17'h00100});
    give_ok(32'h0100_0100, 1);
    end_ok();
    check("postrst_ok", 64'(scr_ok), 64'd1);
    check("postrst_data", 64'(scr_data), 64'h0100_0100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
